free_counter: RTL and testbench
===============================

Name: free_counter

Overview:
- Free-running binary up-counter: counts rising clock edges after reset release.
- Used as a simple timebase or event-count source; output is directly usable as a cycle index.
- Single clock domain, no handshake; the count is visible on the output every cycle.

Parameters:
- WIDTH, 6, counter and output width in bits; legal range 1..32.
- STEP, 1, increment added per clock; legal range 1..MAX_VAL.
- MAX_VAL, 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low; 0 = reset asserted.
- counters  output  WIDTH  current count value, registered.

Port order for positional instantiation: clk, rst, counters.

Behaviour:
- rst low: counters forced to 0 immediately, with no clock needed. It stays 0 while rst is low.
- rst rising, de-assertion: no change at that instant. The first increment happens at the first rising clk edge at which rst is already sampled high.
- Each rising clk edge with rst high: counters <= counters + STEP. The addition is done WIDTH+1 bits wide internally to detect overflow.
- Terminal condition: if counters + STEP > MAX_VAL, the next value is 0 (modulo-(MAX_VAL+1) style wrap to zero, not remainder carry).
- Default parameters, STEP=1 and MAX_VAL=63: sequence 0,1,...,63,0,1,...
- Latency: the output reflects an edge's update immediately after that edge. N edges after release gives counters = N (for N <= MAX_VAL, STEP=1).
- Reset mid-count: asynchronous clear to 0 regardless of clock phase. Counting resumes from 0 after release.
- Reset de-asserted coincident with a clk edge: that edge must not increment. Release is treated as synchronised by the system.
- No enable, load or direction control. The counter runs on every clock while out of reset.
- Output is glitch-free: driven straight from flops, with no combinational path from inputs.
- Parameter checks: illegal parameter combinations (STEP=0, MAX_VAL >= 2**WIDTH) must be flagged by an elaboration-time error.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined: at the terminal condition (counters + STEP > MAX_VAL) the counter holds at MAX_VAL instead of wrapping. It stays there until reset.
- Undefined (default): wrap-to-zero as described in Behaviour.
- The reset behaviour and port list are identical in both builds.

Test Plan:
- Clock period 10 ns, clk starts 0. rst=0 for 0–20 ns, then rst=1. At t=70 ns (edges at 25, 35, 45, 55, 65) -> counters == 5.
- Hold rst=0 for 10 clock edges -> counters stays 0 throughout. Check also that counters goes to 0 immediately when rst falls between edges.
- Run 63 edges after release -> counters == 63. Next edge -> counters == 0 (default build). With COUNTER_SATURATE_EN -> stays 63 for 5 further edges.
- Count to 37, then assert rst mid-cycle (not on an edge) -> counters == 0 within the same cycle. Release -> 1 after the first edge.
- Parameters WIDTH=4, STEP=3, MAX_VAL=10 -> sequence 0,3,6,9,0,3 (saturate build: 0,3,6,9,10,10).
- Random release time within a clock period -> increment count equals the number of rising edges strictly after release.

Source files
------------

// File: rtl/free_counter.sv
// free_counter: free-running binary up-counter used as a timebase or event count.
//
// Each rising clk edge out of reset adds STEP to the count. When count + STEP would
// exceed MAX_VAL, the count wraps to 0. With COUNTER_SATURATE_EN defined, it instead
// holds at MAX_VAL until the next reset.
//
// Parameters:
//   WIDTH    counter/output width in bits (1..32)
//   STEP     increment per clock (1..MAX_VAL)
//   MAX_VAL  terminal count (1..2**WIDTH-1)
//
// Ports:
//   clk       input   rising-edge clock
//   rst       input   asynchronous reset, active-low (0 = reset asserted)
//   counters  output  current count, driven straight from flops
//
// Build option: define COUNTER_SATURATE_EN to saturate at MAX_VAL instead of wrapping.
module free_counter #(
    parameter int unsigned     WIDTH   = 6,
    parameter longint unsigned STEP    = 1,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] counters
);

    // Elaboration-time parameter checks.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("free_counter: WIDTH must be in 1..32");
        end
        if (MAX_VAL == 0 || MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
            $error("free_counter: MAX_VAL must be in 1..2**WIDTH-1");
        end
        if (STEP == 0 || STEP > MAX_VAL) begin : g_bad_step
            $error("free_counter: STEP must be in 1..MAX_VAL");
        end
    endgenerate

    localparam logic [WIDTH:0]   STEP_EXT = STEP[WIDTH:0];
    localparam logic [WIDTH:0]   MAX_EXT  = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_W    = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum;
    logic             terminal;

    // One extra bit so count + STEP can never alias back below MAX_VAL.
    assign sum      = {1'b0, count_q} + STEP_EXT;
    assign terminal = (sum > MAX_EXT);

    always_comb begin
        count_d = sum[WIDTH-1:0];
        if (terminal) begin
`ifdef COUNTER_SATURATE_EN
            count_d = MAX_W;
`else
            count_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign counters = count_q;

endmodule

// File: tb/tb_free_counter.sv
// tb_free_counter: randomized self-checking bench for free_counter.
// Two instances run side by side: default parameters and WIDTH=4/STEP=3/MAX_VAL=10.
// The reference model counts edges since release and derives the expected value
// arithmetically from the wrap period (or the saturation rule).
module tb_free_counter;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] cnt_a;
    logic [3:0] cnt_b;

    int     total = 0;
    int     bad   = 0;
    longint edges = 0;
    bit     mon_en = 1'b0;

    free_counter u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .counters (cnt_a)
    );

    free_counter #(
        .WIDTH   (4),
        .STEP    (3),
        .MAX_VAL (10)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .counters (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Value after n counted edges: multiples of step until the next one would pass maxv,
    // then either periodic restart from 0 or a hold at maxv.
    function automatic longint model_val(input longint n, input longint step,
                                         input longint maxv);
        longint period;
        period = maxv / step + 1;
        if (n < period) return n * step;
        if (SAT) return maxv;
        return (n % period) * step;
    endfunction

    // Rising edges seen with rst already high since the last reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_a", longint'(cnt_a), model_val(edges, 1, 63));
            check("mon_b", longint'(cnt_b), model_val(edges, 3, 10));
        end
    end

    task automatic assert_rst_midcycle();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_clr_a", longint'(cnt_a), 0);
        check("async_clr_b", longint'(cnt_b), 0);
    endtask

    task automatic release_random();
        int unsigned off;
        @(posedge clk);
        off = $urandom_range(1, 9);
        #(off);
        rst = 1'b1;
    endtask

    initial begin
        // Reset held from time 0; after the first edge the count must still be 0.
        #6;
        check("reset_a", longint'(cnt_a), 0);
        check("reset_b", longint'(cnt_b), 0);
        mon_en = 1'b1;

        #14;
        rst = 1'b1;                 // release at 20 ns
        #50;                        // t=70: edges at 25..65
        check("after5_a", longint'(cnt_a), 5);
        check("after5_b", longint'(cnt_b), SAT ? 10 : 3);

        // Up to 63 edges total, then across the terminal count.
        repeat (58) @(posedge clk);
        @(negedge clk);
        check("at_max_a", longint'(cnt_a), 63);
        @(posedge clk);
        @(negedge clk);
        check("past_max_a", longint'(cnt_a), SAT ? 63 : 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("past_max5_a", longint'(cnt_a), SAT ? 63 : 5);

        // Reset held for 10 edges; the monitor checks 0 on every cycle.
        assert_rst_midcycle();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("hold_rst_a", longint'(cnt_a), 0);

        // Count to 37, clear mid-cycle, release, one edge -> 1.
        release_random();
        repeat (37) @(posedge clk);
        @(negedge clk);
        check("at37_a", longint'(cnt_a), 37);
        check("at37_b", longint'(cnt_b), SAT ? 10 : model_val(37, 3, 10));
        assert_rst_midcycle();
        release_random();
        @(posedge clk);
        @(negedge clk);
        check("resume_a", longint'(cnt_a), 1);
        check("resume_b", longint'(cnt_b), 3);

        // Randomized run lengths, reset lengths and release phases.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(1, 90)) @(posedge clk);
            assert_rst_midcycle();
            repeat ($urandom_range(0, 6)) @(posedge clk);
            release_random();
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
